mem_access_ctrl: RTL

//  Sequences data-memory loads/stores decoded by the control unit onto a

---
 rtl/mem_access_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: turns load/store decode into a req/ack word bus
// transaction, stalls the core meanwhile, and shapes store lanes / load results.
// Optional alignment checking is enabled by defining ALIGN_CHECK_EN.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            data_width,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  stall,
  output logic                  done,
  output logic                  bus_err,
  output logic                  misalign_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ack,
  input  logic [31:0]           bus_rdata
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [1:0]              off_q, off_d;
  logic [2:0]              width_q, width_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic        access;
  logic        is_half;
  logic        is_byte;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_c;

  assign access  = mem_read | mem_write;
  assign is_half = (data_width == 3'b001) || (data_width == 3'b101);
  assign is_byte = (data_width == 3'b010) || (data_width == 3'b110);

`ifdef ALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic misaligned_c;

  // Bytes are never misaligned; undefined codes fall into the word rule.
  assign misaligned_c = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
  assign misalign_err = (state_q == RESP) && mis_q;
`else
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    if (is_half) begin
      be_c    = 4'b0011 << {addr[1], 1'b0};
      wdata_c = {2{wdata[15:0]}};
    end else if (is_byte) begin
      be_c    = 4'b0001 << addr[1:0];
      wdata_c = {4{wdata[7:0]}};
    end
  end

  // Lane extraction uses the offset and width captured when the access started.
  always_comb begin
    byte_lane = bus_rdata[7:0];
    case (off_q)
      2'd1:    byte_lane = bus_rdata[15:8];
      2'd2:    byte_lane = bus_rdata[23:16];
      2'd3:    byte_lane = bus_rdata[31:24];
      default: byte_lane = bus_rdata[7:0];
    endcase
    half_lane = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (width_q)
      3'b010:  load_c = {{24{byte_lane[7]}}, byte_lane};
      3'b110:  load_c = {24'd0, byte_lane};
      3'b001:  load_c = {{16{half_lane[15]}}, half_lane};
      3'b101:  load_c = {16'd0, half_lane};
      default: load_c = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    width_d = width_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
`ifdef ALIGN_CHECK_EN
        mis_d   = 1'b0;
`endif
        if (access) begin
          we_d    = mem_write;
          addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
          be_d    = be_c;
          wdata_d = wdata_c;
          off_d   = addr[1:0];
          width_d = data_width;
          state_d = REQ;
`ifdef ALIGN_CHECK_EN
          if (misaligned_c) begin
            mis_d   = 1'b1;
            state_d = RESP;
          end
`endif
        end
      end
      REQ: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (bus_ack) begin
          state_d = RESP;
          rdata_d = we_q ? 32'd0 : load_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      width_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      width_q <= width_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // RESP deasserts stall so the pipeline moves past this instruction exactly once.
  assign stall     = ((state_q == IDLE) && access) || (state_q == REQ);
  assign done      = (state_q == RESP);
  assign bus_err   = (state_q == RESP) && err_q;
  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule
